// File: rtl/answer_judge.sv
// answer_judge: checks factor answers, arbitrates rounds, times out, keeps HP.
// Optional WRONG_PENALTY_EN: a wrong answer also costs the player one HP.
module answer_judge #(
  parameter int W           = 8,
  parameter int HP_INIT     = 3,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [3:0]     STATE,
  input  logic [2*W-1:0] QNUM,
  input  logic [W-1:0]   ANS_A,
  input  logic [W-1:0]   ANS_B,
  input  logic           ANS_VALID,
  input  logic           OPP_DONE,
  output logic [1:0]     JUDG,
  output logic           WRONG,
  output logic [1:0]     HP,
  output logic [2:0]     MY_HP,
  output logic [2:0]     OPP_HP
);

  localparam logic [3:0] ST_READY = 4'b0010;
  localparam logic [3:0] ST_QUES  = 4'b0011;
  localparam logic [3:0] ST_INPUT = 4'b0100;

  localparam logic [28:0] TMO_LAST = 29'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  HP_RST   = 3'(HP_INIT);

  logic [1:0]  r_judg;
  logic        r_lock;
  logic        r_wrong;
  logic [28:0] r_cnt;
  logic [2:0]  r_my_hp;
  logic [2:0]  r_opp_hp;

  logic [2*W-1:0] w_prod;
  logic           w_ok;
  logic           w_open;
  logic           w_clr;
  logic           w_draw;
  logic           w_win;
  logic           w_loss;
  logic           w_bad;
  logic           w_tmo;
  logic           w_lose_rnd;
  logic           w_pen;
  logic           w_pen_ko;
  logic           w_judge;
  logic [1:0]     w_judg_nxt;
  logic [1:0]     w_hp;
  logic           w_new_game;
  logic [2:0]     w_my_dec;
  logic [2:0]     w_my_nxt;
  logic [2:0]     w_opp_nxt;

  // full-width product: no truncation of the factor multiply
  assign w_prod = (2*W)'(ANS_A) * (2*W)'(ANS_B);

  // factors of 0 or 1 are trivial and never accepted
  assign w_ok = (|ANS_A[W-1:1]) &&
                (|ANS_B[W-1:1]) &&
                (w_prod == QNUM);

  // STATE stays INPUT through result states; lock stops re-judging
  assign w_open = (STATE == ST_INPUT) && !r_lock;
  assign w_clr  = (STATE == ST_READY) || (STATE == ST_QUES);

  assign w_draw = w_open & ANS_VALID & w_ok & OPP_DONE;
  assign w_win  = w_open & ANS_VALID & w_ok & ~OPP_DONE;
  assign w_loss = w_open & OPP_DONE & ~(ANS_VALID & w_ok);
  assign w_bad  = w_open & ANS_VALID & ~w_ok;

  // any strobe beats the timeout; a lost race just fires next cycle
  assign w_tmo = w_open & ~ANS_VALID & ~OPP_DONE &
                 (r_cnt >= TMO_LAST);

  assign w_lose_rnd = w_loss | w_tmo;

`ifdef WRONG_PENALTY_EN
  assign w_pen    = w_bad;
  assign w_pen_ko = w_bad & ~w_loss & (r_my_hp <= 3'd1);
`else
  assign w_pen    = 1'b0;
  assign w_pen_ko = 1'b0;
`endif

  assign w_judge = w_draw | w_win | w_lose_rnd | w_pen_ko;

  // pick the round verdict; cases are mutually exclusive
  always_comb begin
    w_judg_nxt = r_judg;
    unique case (1'b1)
      w_draw:             w_judg_nxt = 2'b11;
      w_win:              w_judg_nxt = 2'b01;
      w_lose_rnd,
      w_pen_ko:           w_judg_nxt = 2'b10;
      default:            w_judg_nxt = r_judg;
    endcase
  end

  // game status straight from the counters
  always_comb begin
    w_hp = 2'b00;
    if (r_opp_hp == 3'd0)
      w_hp = 2'b01;
    else if (r_my_hp == 3'd0)
      w_hp = 2'b10;
  end

  assign w_new_game = (STATE == ST_READY) && (w_hp != 2'b00);

  // saturating HP arithmetic; penalty may stack on a lost round
  assign w_my_dec = {2'b00, w_lose_rnd} + {2'b00, w_pen};
  assign w_my_nxt = (r_my_hp > w_my_dec) ?
                    (r_my_hp - w_my_dec) : 3'd0;
  assign w_opp_nxt = (r_opp_hp != 3'd0) ?
                     (r_opp_hp - 3'd1) : 3'd0;

  // verdict register and lock; cleared when a new question starts
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_judg <= 2'b00;
      r_lock <= 1'b0;
    end else if (w_clr) begin
      r_judg <= 2'b00;
      r_lock <= 1'b0;
    end else if (w_judge) begin
      r_judg <= w_judg_nxt;
      r_lock <= 1'b1;
    end
  end

  // one-cycle wrong-answer pulse
  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_wrong <= 1'b0;
    else
      r_wrong <= w_bad;
  end

  // answer timeout counter, runs only while the window is open
  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_cnt <= '0;
    else if (!w_open || w_judge)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 29'd1;
  end

  // player hit points
  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_my_hp <= HP_RST;
    else if (w_new_game)
      r_my_hp <= HP_RST;
    else if (w_my_dec != 3'd0)
      r_my_hp <= w_my_nxt;
  end

  // opponent hit points
  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_opp_hp <= HP_RST;
    else if (w_new_game)
      r_opp_hp <= HP_RST;
    else if (w_win)
      r_opp_hp <= w_opp_nxt;
  end

  assign JUDG   = r_judg;
  assign WRONG  = r_wrong;
  assign HP     = w_hp;
  assign MY_HP  = r_my_hp;
  assign OPP_HP = r_opp_hp;

endmodule
